change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pays out change after a vend: takes an amount in coin units over a valid/ready request, then ejects
//  coins one at a time from two hoppers (large and small). Each eject waits for the exit sensor to
//  confirm the coin before the next one starts. Large coins go out first. Sits downstream of the
//  vending controller and drives the hopper solenoids.
// PARAMETERS
//  AMT_W        8   width of amount / remaining / shortfall fields
//  INV_W        8   width of each hopper inventory counter
//  HI_VAL       2   value of one large coin in units (>=2)
//  LO_VAL       1   value of one small coin in units (fixed 1)
//  PULSE_CYC    4   cycles the eject solenoid is held high per coin (>=1)
//  ACK_TIMEOUT  16  cycles allowed after the pulse ends for coin_seen before fault (>=1)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high; clears all state
//  req_valid    in   1      change request present
//  req_ready    out  1      high only in IDLE; request accepted when valid&ready
//  req_amount   in   AMT_W  change owed, in units
//  load_hi      in   1      inventory load strobe for the large hopper (honoured in IDLE only)
//  load_lo      in   1      inventory load strobe for the small hopper (honoured in IDLE only)
//  load_count   in   INV_W  value written to the selected inventory counter
//  coin_seen    in   1      exit sensor, one-cycle pulse per coin
//  eject_hi     out  1      large-hopper solenoid
//  eject_lo     out  1      small-hopper solenoid
//  done         out  1      one-cycle pulse: full amount paid
//  fault        out  1      one-cycle pulse: aborted; see fault_code and shortfall
//  fault_code   out  2      0=none, 1=insufficient inventory, 2=sensor timeout
//  shortfall    out  AMT_W  units still unpaid; valid with done (0) and fault
//  stray_coin   out  1      one-cycle pulse: coin_seen arrived outside WAIT_ACK
//  inv_hi       out  INV_W  live large-coin count
//  inv_lo       out  INV_W  live small-coin count
// BEHAVIOUR
//  Reset: state=IDLE; inventories=0; remaining=0; every output 0 except req_ready=1.
//  FSM:
//  - IDLE: on accept, remaining<=req_amount, then go to SELECT.
//    On load_hi / load_lo (no accept that cycle), write load_count; if both strobes are high, both
//    counters take load_count. A load that coincides with an accept is ignored.
//  - SELECT (1 cycle):
//    remaining==0 -> DONE.
//    remaining>=HI_VAL && inv_hi>0 -> PULSE(hi).
//    else inv_lo>0 -> PULSE(lo).
//    else -> FAULT with code 1.
//  - PULSE: the chosen eject output is high for exactly PULSE_CYC cycles; only one eject is ever high.
//  - WAIT_ACK: the timer starts at 0 the cycle after the pulse ends.
//    coin_seen -> remaining -= coin value, the matching inventory -= 1, go to SELECT.
//    timer==ACK_TIMEOUT-1 with no coin_seen -> FAULT with code 2; inventory and remaining unchanged.
//    coin_seen in the final timer cycle wins over the timeout.
//  - DONE: done=1 and shortfall=0 for 1 cycle, then IDLE.
//  - FAULT: fault=1, fault_code set, shortfall=remaining for 1 cycle, then IDLE.
//  - fault_code and shortfall hold their values until the next accept.
//  coin_seen during PULSE counts as the ack and is latched; the FSM moves on when the pulse ends.
//  coin_seen in any other state except WAIT_ACK -> stray_coin pulse only; no counter changes.
//  Arithmetic: remaining never goes below 0, because a large coin is chosen only if remaining>=HI_VAL.
//  Inventory decrement saturates at 0 (defensive).
//  Latency, zero amount: accept -> SELECT -> DONE; done is high 2 cycles after the accept edge.
//  reset mid-payout: ejects drop at that edge, no done/fault pulse, and inventories clear to 0.
// STRUCTURE
//  Shared package (vend_pkg):
//    state enum {IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT};
//    fault-code constants FC_NONE / FC_NOINV / FC_TIMEOUT;
//    coin value constants.
//  One sub-module, hopper_timer: a loadable down-counter used for both the pulse width and the ack
//  timeout, with outputs expired and busy.
// TESTING
//  1. load_hi=3, load_lo=3; req 5 -> hi, hi, lo ejects, each PULSE_CYC wide; ack each;
//     done, shortfall=0, inv_hi=1, inv_lo=2.
//  2. inv_hi=0, inv_lo=2; req 3 -> two lo coins, then fault, code=1, shortfall=1, inv_lo=0.
//  3. inv_lo=1; req 1, no coin_seen -> fault code=2 exactly ACK_TIMEOUT cycles after the pulse ends;
//     inv_lo stays 1.
//  4. req 0 -> done 2 cycles after accept, no eject; also coin_seen in IDLE -> stray_coin, counts unchanged.
//  5. reset asserted during the 2nd PULSE of a req 4 -> eject low next edge, req_ready=1,
//     inv=0, no done/fault.
//  6. coin_seen on the last ACK_TIMEOUT cycle -> counted, no fault; load_hi while busy -> ignored.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
package vend_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  // Fault codes reported on fault_code
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_NOINV   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  // Coin values in units; the small coin is always worth one unit
  localparam int COIN_HI_VAL = 2;
  localparam int COIN_LO_VAL = 1;

  // Counter width able to hold the larger of two load values
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, inventory-load, sensor and solenoid signals of the change dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 8,
  parameter int INV_W = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             load_hi;
  logic             load_lo;
  logic [INV_W-1:0] load_count;
  logic             coin_seen;
  logic             eject_hi;
  logic             eject_lo;
  logic             done;
  logic             fault;
  logic [1:0]       fault_code;
  logic [AMT_W-1:0] shortfall;
  logic             stray_coin;
  logic [INV_W-1:0] inv_hi;
  logic [INV_W-1:0] inv_lo;

  // Vending-controller side
  modport master (
    output req_valid, req_amount, load_hi, load_lo, load_count, coin_seen,
    input  req_ready, eject_hi, eject_lo, done, fault, fault_code, shortfall,
           stray_coin, inv_hi, inv_lo
  );

  // Dispenser side
  modport slave (
    input  req_valid, req_amount, load_hi, load_lo, load_count, coin_seen,
    output req_ready, eject_hi, eject_lo, done, fault, fault_code, shortfall,
           stray_coin, inv_hi, inv_lo
  );

endinterface

// File: rtl/change_dispenser_hopper_timer.sv
// Loadable down-counter shared by the eject pulse width and the ack timeout.
// expired flags the last counted cycle (count==1); busy is high while counting.
module hopper_timer
  import vend_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired,
  output logic             busy
);

  logic [CNT_W-1:0] count_reg;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign busy    = (count_reg != '0);
  assign expired = (count_reg == CNT_W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount from a large and a small hopper, one
// coin at a time, large coins first, each confirmed by the exit sensor.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 8,
  parameter int HI_VAL      = COIN_HI_VAL,
  parameter int PULSE_CYC   = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  change_dispenser_if.slave bus
);

  localparam int CNT_W = timer_width(PULSE_CYC, ACK_TIMEOUT);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] remaining_reg;
  logic [INV_W-1:0] inv_hi_reg, inv_lo_reg;
  logic [1:0]       fault_code_reg;
  logic [AMT_W-1:0] shortfall_reg;
  logic             stray_reg;
  logic             sel_hi_reg;
  logic             ack_reg;

  logic             accept;
  logic             pick_hi, pick_lo;
  logic             coin_taken;
  logic             timeout_hit;
  logic [AMT_W-1:0] coin_value;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expired, timer_busy;

  hopper_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired),
    .busy       (timer_busy)
  );

  assign accept  = bus.req_valid && (state_reg == IDLE);
  // A large coin is only chosen when it cannot overpay, so remaining never underflows
  assign pick_hi = (remaining_reg >= AMT_W'(HI_VAL)) && (inv_hi_reg != '0);
  assign pick_lo = !pick_hi && (inv_lo_reg != '0);
  assign coin_value = sel_hi_reg ? AMT_W'(HI_VAL) : AMT_W'(COIN_LO_VAL);
  // A coin is credited either on a sensor hit while waiting, or at the end of a
  // pulse during which the sensor already fired
  assign coin_taken = ((state_reg == WAIT_ACK) && bus.coin_seen) ||
                      ((state_reg == PULSE) && timer_expired && (ack_reg || bus.coin_seen));
  assign timeout_hit = (state_reg == WAIT_ACK) && !bus.coin_seen && timer_expired;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and timer control
  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = SELECT;
      end
      SELECT: begin
        if (remaining_reg == '0) begin
          state_next = DONE;
        end else if (pick_hi || pick_lo) begin
          state_next  = PULSE;
          timer_load  = 1'b1;
          timer_value = CNT_W'(PULSE_CYC);
        end else begin
          state_next = FAULT;
        end
      end
      PULSE: begin
        if (timer_expired) begin
          if (ack_reg || bus.coin_seen) begin
            state_next = SELECT;
          end else begin
            state_next  = WAIT_ACK;
            timer_load  = 1'b1;
            timer_value = CNT_W'(ACK_TIMEOUT);
          end
        end
      end
      WAIT_ACK: begin
        if (bus.coin_seen) begin
          state_next = SELECT;
        end else if (timer_expired) begin
          state_next = FAULT;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: amount, inventories, result fields and sensor bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_reg  <= '0;
      inv_hi_reg     <= '0;
      inv_lo_reg     <= '0;
      fault_code_reg <= FC_NONE;
      shortfall_reg  <= '0;
      stray_reg      <= 1'b0;
      sel_hi_reg     <= 1'b0;
      ack_reg        <= 1'b0;
    end else begin
      // A second sensor hit inside one pulse is also unexpected
      stray_reg <= bus.coin_seen && (state_reg != WAIT_ACK) &&
                   !((state_reg == PULSE) && !ack_reg);

      if (accept) begin
        remaining_reg  <= bus.req_amount;
        fault_code_reg <= FC_NONE;
        shortfall_reg  <= '0;
      end else if (state_reg == IDLE) begin
        if (bus.load_hi) inv_hi_reg <= bus.load_count;
        if (bus.load_lo) inv_lo_reg <= bus.load_count;
      end

      if (state_reg == SELECT) begin
        sel_hi_reg <= pick_hi;
        if (remaining_reg == '0) begin
          fault_code_reg <= FC_NONE;
          shortfall_reg  <= '0;
        end else if (!pick_hi && !pick_lo) begin
          fault_code_reg <= FC_NOINV;
          shortfall_reg  <= remaining_reg;
        end
      end

      if (state_reg == PULSE) begin
        ack_reg <= timer_expired ? 1'b0 : (ack_reg || bus.coin_seen);
      end else begin
        ack_reg <= 1'b0;
      end

      if (coin_taken) begin
        remaining_reg <= remaining_reg - coin_value;
        if (sel_hi_reg) begin
          if (inv_hi_reg != '0) inv_hi_reg <= inv_hi_reg - INV_W'(1);
        end else begin
          if (inv_lo_reg != '0) inv_lo_reg <= inv_lo_reg - INV_W'(1);
        end
      end

      if (timeout_hit) begin
        fault_code_reg <= FC_TIMEOUT;
        shortfall_reg  <= remaining_reg;
      end
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.eject_hi   = (state_reg == PULSE) && sel_hi_reg && timer_busy;
  assign bus.eject_lo   = (state_reg == PULSE) && !sel_hi_reg && timer_busy;
  assign bus.done       = (state_reg == DONE);
  assign bus.fault      = (state_reg == FAULT);
  assign bus.fault_code = fault_code_reg;
  assign bus.shortfall  = shortfall_reg;
  assign bus.stray_coin = stray_reg;
  assign bus.inv_hi     = inv_hi_reg;
  assign bus.inv_lo     = inv_lo_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser.
module tb_change_dispenser;

  localparam int PULSE_CYC   = 4;
  localparam int ACK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  change_dispenser_if #(.AMT_W(8), .INV_W(8)) bus ();

  change_dispenser #(
    .AMT_W(8), .INV_W(8), .HI_VAL(2), .PULSE_CYC(PULSE_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic hi, input logic lo, input logic [7:0] cnt);
    bus.load_hi = hi; bus.load_lo = lo; bus.load_count = cnt;
    tick();
    bus.load_hi = 1'b0; bus.load_lo = 1'b0; bus.load_count = 8'd0;
  endtask

  task automatic send_req(input logic [7:0] amt);
    bus.req_valid = 1'b1; bus.req_amount = amt;
    tick();
    bus.req_valid = 1'b0; bus.req_amount = 8'd0;
  endtask

  task automatic ack();
    bus.coin_seen = 1'b1;
    tick();
    bus.coin_seen = 1'b0;
  endtask

  // Wait for an eject, then measure how long it stays high and which hopper fired
  task automatic observe_pulse(output logic saw_hi, output logic saw_lo, output int width,
                               output bit both, output bit timeout);
    int n;
    saw_hi = 1'b0; saw_lo = 1'b0; width = 0; both = 1'b0; n = 0;
    while (!(bus.eject_hi || bus.eject_lo) && n < 40) begin
      tick(); n++;
    end
    timeout = !(bus.eject_hi || bus.eject_lo);
    while ((bus.eject_hi || bus.eject_lo) && width < 40) begin
      if (bus.eject_hi) saw_hi = 1'b1;
      if (bus.eject_lo) saw_lo = 1'b1;
      if (bus.eject_hi && bus.eject_lo) both = 1'b1;
      width++;
      tick();
    end
  endtask

  task automatic wait_end(output bit got_done, output bit got_fault);
    int n;
    n = 0;
    while (!bus.done && !bus.fault && n < 60) begin
      tick(); n++;
    end
    got_done  = bus.done;
    got_fault = bus.fault;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vec_cnt++;
    if (bus.req_ready !== 1'b1 || bus.eject_hi !== 1'b0 || bus.eject_lo !== 1'b0 ||
        bus.done !== 1'b0 || bus.fault !== 1'b0 || bus.stray_coin !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got ready=%0b ehi=%0b elo=%0b done=%0b fault=%0b stray=%0b, want 1 0 0 0 0 0",
               bus.req_ready, bus.eject_hi, bus.eject_lo, bus.done, bus.fault, bus.stray_coin);
    end
    vec_cnt++;
    if (bus.fault_code !== 2'd0 || bus.shortfall !== 8'd0 || bus.inv_hi !== 8'd0 || bus.inv_lo !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset_data: got code=%0d short=%0d inv_hi=%0d inv_lo=%0d, want all 0",
               bus.fault_code, bus.shortfall, bus.inv_hi, bus.inv_lo);
    end
    reset = 1'b0;
    tick();
    $display("reset: ready=%0b inv_hi=%0d inv_lo=%0d", bus.req_ready, bus.inv_hi, bus.inv_lo);
  endtask

  task automatic test_full_payout();
    logic exp_hi [3];
    logic sh, sl;
    int   w;
    bit   bo, to, gd, gf;
    exp_hi = '{1'b1, 1'b1, 1'b0};
    do_load(1'b1, 1'b1, 8'd3);
    send_req(8'd5);
    for (int i = 0; i < 3; i++) begin
      observe_pulse(sh, sl, w, bo, to);
      vec_cnt++;
      if (to || sh !== exp_hi[i] || sl !== !exp_hi[i] || bo) begin
        err_cnt++;
        $display("FAIL t1_coin%0d_kind: got hi=%0b lo=%0b both=%0b timeout=%0b, want hi=%0b lo=%0b",
                 i, sh, sl, bo, to, exp_hi[i], !exp_hi[i]);
      end
      vec_cnt++;
      if (w !== PULSE_CYC) begin
        err_cnt++;
        $display("FAIL t1_coin%0d_width: got %0d, want %0d", i, w, PULSE_CYC);
      end
      ack();
    end
    wait_end(gd, gf);
    vec_cnt++;
    if (gd !== 1'b1 || gf !== 1'b0 || bus.shortfall !== 8'd0 || bus.fault_code !== 2'd0) begin
      err_cnt++;
      $display("FAIL t1_done: got done=%0b fault=%0b short=%0d code=%0d, want 1 0 0 0",
               gd, gf, bus.shortfall, bus.fault_code);
    end
    vec_cnt++;
    if (bus.inv_hi !== 8'd1 || bus.inv_lo !== 8'd2) begin
      err_cnt++;
      $display("FAIL t1_inv: got hi=%0d lo=%0d, want hi=1 lo=2", bus.inv_hi, bus.inv_lo);
    end
    $display("t1 req 5: done=%0b short=%0d inv_hi=%0d inv_lo=%0d", gd, bus.shortfall, bus.inv_hi, bus.inv_lo);
    tick();
  endtask

  task automatic test_no_inventory();
    logic sh, sl;
    int   w;
    bit   bo, to, gd, gf;
    do_load(1'b1, 1'b0, 8'd0);
    do_load(1'b0, 1'b1, 8'd2);
    send_req(8'd3);
    for (int i = 0; i < 2; i++) begin
      observe_pulse(sh, sl, w, bo, to);
      vec_cnt++;
      if (to || sh !== 1'b0 || sl !== 1'b1 || w !== PULSE_CYC) begin
        err_cnt++;
        $display("FAIL t2_coin%0d: got hi=%0b lo=%0b width=%0d timeout=%0b, want lo only width %0d",
                 i, sh, sl, w, to, PULSE_CYC);
      end
      ack();
    end
    wait_end(gd, gf);
    vec_cnt++;
    if (gf !== 1'b1 || gd !== 1'b0 || bus.fault_code !== 2'd1 || bus.shortfall !== 8'd1) begin
      err_cnt++;
      $display("FAIL t2_fault: got fault=%0b done=%0b code=%0d short=%0d, want 1 0 1 1",
               gf, gd, bus.fault_code, bus.shortfall);
    end
    vec_cnt++;
    if (bus.inv_lo !== 8'd0 || bus.inv_hi !== 8'd0) begin
      err_cnt++;
      $display("FAIL t2_inv: got hi=%0d lo=%0d, want 0 0", bus.inv_hi, bus.inv_lo);
    end
    tick();
    vec_cnt++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 2'd1 || bus.shortfall !== 8'd1 || bus.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL t2_hold: got fault=%0b code=%0d short=%0d ready=%0b, want 0 1 1 1",
               bus.fault, bus.fault_code, bus.shortfall, bus.req_ready);
    end
    $display("t2 req 3: fault code=%0d short=%0d inv_lo=%0d", bus.fault_code, bus.shortfall, bus.inv_lo);
  endtask

  task automatic test_timeout();
    logic sh, sl;
    int   w, n;
    bit   bo, to;
    do_load(1'b0, 1'b1, 8'd1);
    send_req(8'd1);
    observe_pulse(sh, sl, w, bo, to);
    vec_cnt++;
    if (to || sl !== 1'b1 || sh !== 1'b0 || w !== PULSE_CYC) begin
      err_cnt++;
      $display("FAIL t3_pulse: got hi=%0b lo=%0b width=%0d timeout=%0b, want lo width %0d",
               sh, sl, w, to, PULSE_CYC);
    end
    n = 0;
    while (!bus.fault && n < 40) begin
      tick(); n++;
    end
    vec_cnt++;
    if (bus.fault !== 1'b1 || n !== ACK_TIMEOUT) begin
      err_cnt++;
      $display("FAIL t3_latency: got fault=%0b after %0d cycles, want fault after %0d", bus.fault, n, ACK_TIMEOUT);
    end
    vec_cnt++;
    if (bus.fault_code !== 2'd2 || bus.shortfall !== 8'd1 || bus.inv_lo !== 8'd1) begin
      err_cnt++;
      $display("FAIL t3_fields: got code=%0d short=%0d inv_lo=%0d, want 2 1 1",
               bus.fault_code, bus.shortfall, bus.inv_lo);
    end
    $display("t3 req 1: timeout after %0d cycles code=%0d inv_lo=%0d", n, bus.fault_code, bus.inv_lo);
    tick();
  endtask

  task automatic test_zero_and_stray();
    send_req(8'd0);
    vec_cnt++;
    if (bus.done !== 1'b0 || bus.eject_hi !== 1'b0 || bus.eject_lo !== 1'b0) begin
      err_cnt++;
      $display("FAIL t4_early: got done=%0b ehi=%0b elo=%0b one cycle after accept, want 0 0 0",
               bus.done, bus.eject_hi, bus.eject_lo);
    end
    tick();
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.shortfall !== 8'd0 || bus.fault_code !== 2'd0 ||
        bus.eject_hi !== 1'b0 || bus.eject_lo !== 1'b0) begin
      err_cnt++;
      $display("FAIL t4_done: got done=%0b short=%0d code=%0d ehi=%0b elo=%0b, want 1 0 0 0 0",
               bus.done, bus.shortfall, bus.fault_code, bus.eject_hi, bus.eject_lo);
    end
    $display("t4 req 0: done=%0b short=%0d", bus.done, bus.shortfall);
    tick();
    bus.coin_seen = 1'b1;
    tick();
    bus.coin_seen = 1'b0;
    vec_cnt++;
    if (bus.stray_coin !== 1'b1 || bus.inv_lo !== 8'd1 || bus.inv_hi !== 8'd0) begin
      err_cnt++;
      $display("FAIL t4_stray: got stray=%0b inv_hi=%0d inv_lo=%0d, want 1 0 1",
               bus.stray_coin, bus.inv_hi, bus.inv_lo);
    end
    tick();
    vec_cnt++;
    if (bus.stray_coin !== 1'b0) begin
      err_cnt++;
      $display("FAIL t4_stray_pulse: got stray=%0b a cycle later, want 0", bus.stray_coin);
    end
    $display("t4 stray coin in IDLE: inv_lo=%0d", bus.inv_lo);
  endtask

  task automatic test_reset_mid_payout();
    logic sh, sl;
    int   w, n;
    bit   bo, to, seen_end;
    do_load(1'b1, 1'b1, 8'd3);
    send_req(8'd4);
    observe_pulse(sh, sl, w, bo, to);
    ack();
    n = 0;
    while (!bus.eject_hi && n < 20) begin
      tick(); n++;
    end
    vec_cnt++;
    if (bus.eject_hi !== 1'b1) begin
      err_cnt++;
      $display("FAIL t5_second_pulse: got eject_hi=%0b, want 1", bus.eject_hi);
    end
    tick();
    reset = 1'b1;
    tick();
    vec_cnt++;
    if (bus.eject_hi !== 1'b0 || bus.eject_lo !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.done !== 1'b0 || bus.fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL t5_ctrl: got ehi=%0b elo=%0b ready=%0b done=%0b fault=%0b, want 0 0 1 0 0",
               bus.eject_hi, bus.eject_lo, bus.req_ready, bus.done, bus.fault);
    end
    vec_cnt++;
    if (bus.inv_hi !== 8'd0 || bus.inv_lo !== 8'd0) begin
      err_cnt++;
      $display("FAIL t5_inv: got hi=%0d lo=%0d, want 0 0", bus.inv_hi, bus.inv_lo);
    end
    reset = 1'b0;
    seen_end = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.fault || bus.eject_hi || bus.eject_lo) seen_end = 1'b1;
    end
    vec_cnt++;
    if (seen_end !== 1'b0) begin
      err_cnt++;
      $display("FAIL t5_quiet: got done/fault/eject activity after reset, want none");
    end
    $display("t5 req 4 reset mid-pulse: ready=%0b inv_hi=%0d inv_lo=%0d", bus.req_ready, bus.inv_hi, bus.inv_lo);
  endtask

  task automatic test_last_cycle_ack();
    logic sh, sl;
    int   w;
    bit   bo, to;
    do_load(1'b0, 1'b1, 8'd1);
    send_req(8'd1);
    observe_pulse(sh, sl, w, bo, to);
    for (int k = 0; k < ACK_TIMEOUT - 1; k++) begin
      bus.load_hi    = (k == 5);
      bus.load_count = (k == 5) ? 8'd9 : 8'd0;
      tick();
    end
    bus.load_hi = 1'b0; bus.load_count = 8'd0;
    ack();
    vec_cnt++;
    if (bus.fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL t6_no_fault: got fault=%0b after last-cycle ack, want 0", bus.fault);
    end
    tick();
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.shortfall !== 8'd0 || bus.fault_code !== 2'd0) begin
      err_cnt++;
      $display("FAIL t6_done: got done=%0b short=%0d code=%0d, want 1 0 0",
               bus.done, bus.shortfall, bus.fault_code);
    end
    vec_cnt++;
    if (bus.inv_lo !== 8'd0 || bus.inv_hi !== 8'd0) begin
      err_cnt++;
      $display("FAIL t6_inv: got hi=%0d lo=%0d, want 0 0 (busy load ignored)", bus.inv_hi, bus.inv_lo);
    end
    $display("t6 req 1 ack on last timer cycle: done=%0b inv_hi=%0d inv_lo=%0d", bus.done, bus.inv_hi, bus.inv_lo);
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = 8'd0;
    bus.load_hi    = 1'b0;
    bus.load_lo    = 1'b0;
    bus.load_count = 8'd0;
    bus.coin_seen  = 1'b0;
    test_reset();
    test_full_payout();
    test_no_inventory();
    test_timeout();
    test_zero_and_stray();
    test_reset_mid_payout();
    test_last_cycle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
